// File: rtl/esdi_pkg.sv
// rtl/esdi_pkg.sv - shared ESDI serial channel constants, state type and parity helper
package esdi_pkg;

    localparam int CMD_FRAME_BITS = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_C_DLY,
        S_C_ACK,
        S_EXEC,
        S_R_WAIT,
        S_R_DLY,
        S_R_ACK,
        S_DONE
    } esdi_state_t;

    // Parity bit that makes the total count of ones in {word, bit} odd
    function automatic logic odd_parity(input logic [15:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/esdi_sync_edge.sv
// rtl/esdi_sync_edge.sv - N-stage synchroniser with optional rise/fall pulse outputs
module esdi_sync_edge #(
    parameter int STAGES      = 2,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic prev_q;

            // One-cycle delayed copy of the synchronised level for edge detection
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= dout;
                end
            end

            assign rise = dout & ~prev_q;
            assign fall = ~dout & prev_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/esdi_drive_serial_responder.sv
// rtl/esdi_drive_serial_responder.sv - drive-side ESDI serial command/status responder
module esdi_drive_serial_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 4,
    parameter int TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        transfer_req,
    input  logic        command_data,
    output logic        transfer_ack,
    output logic        confstat_data,
    output logic        command_complete,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        cmd_parity_err,
    input  logic        resp_valid,
    input  logic        resp_has_data,
    input  logic [15:0] resp_word,
    output logic        resp_ready,
    output logic        frame_err
);

    import esdi_pkg::*;

    localparam int              DW        = $clog2(ACK_DELAY + 1) + 1;
    localparam logic [DW-1:0]   DLY_LAST  = DW'(ACK_DELAY - 1);
    localparam logic [DW-1:0]   DLY_FULL  = DW'(ACK_DELAY);
    localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [4:0]      LAST_BIT  = 5'(CMD_FRAME_BITS - 1);

    logic req_s, req_rise, req_fall;
    logic data_s, data_rise, data_fall;
    logic unused_data_edges;

    esdi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_req_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (transfer_req),
        .dout   (req_s),
        .rise   (req_rise),
        .fall   (req_fall)
    );

    esdi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_data_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (command_data),
        .dout   (data_s),
        .rise   (data_rise),
        .fall   (data_fall)
    );

    assign unused_data_edges = data_rise | data_fall;

    esdi_state_t   state, state_d;
    logic [DW-1:0] dly_cnt, dly_cnt_d;
    logic [4:0]    bitcnt, bitcnt_d;
    logic          waiting, waiting_d;
    logic [16:0]   shift, shift_d;
    logic [16:0]   tx, tx_d;
    logic [15:0]   tmo_cnt, tmo_cnt_d;
    logic          ack_q, ack_d;
    logic          conf_q, conf_d;
    logic          clr_q, clr_d;
    logic          cc_q, cc_d;
    logic          cv_q, cv_d;
    logic [15:0]   cw_q, cw_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          tmo_run, tmo_hit;

    // State and datapath registers; reset drops ack and status data immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
            bitcnt  <= '0;
            waiting <= 1'b0;
            shift   <= '0;
            tx      <= '0;
            tmo_cnt <= '0;
            ack_q   <= 1'b0;
            conf_q  <= 1'b0;
            clr_q   <= 1'b0;
            cc_q    <= 1'b1;
            cv_q    <= 1'b0;
            cw_q    <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state   <= state_d;
            dly_cnt <= dly_cnt_d;
            bitcnt  <= bitcnt_d;
            waiting <= waiting_d;
            shift   <= shift_d;
            tx      <= tx_d;
            tmo_cnt <= tmo_cnt_d;
            ack_q   <= ack_d;
            conf_q  <= conf_d;
            clr_q   <= clr_d;
            cc_q    <= cc_d;
            cv_q    <= cv_d;
            cw_q    <= cw_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state, handshake sequencing and mid-frame timeout
    always_comb begin
        state_d   = state;
        dly_cnt_d = dly_cnt;
        bitcnt_d  = bitcnt;
        waiting_d = waiting;
        shift_d   = shift;
        tx_d      = tx;
        ack_d     = ack_q;
        conf_d    = conf_q;
        clr_d     = 1'b0;
        cc_d      = cc_q;
        cv_d      = 1'b0;
        cw_d      = cw_q;
        pe_d      = pe_q;
        fe_d      = 1'b0;

        // Status bit stays on the wire one cycle past the ack fall
        if (clr_q) begin
            conf_d = 1'b0;
        end

        // Only states that are waiting on the host for a req edge are timed
        tmo_run = (state == S_C_ACK) || (state == S_R_WAIT) || (state == S_R_ACK) ||
                  ((state == S_C_DLY) && waiting);
        if (req_rise || req_fall || !tmo_run) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt + 16'd1;
        end
        tmo_hit = tmo_run && !req_rise && !req_fall && (tmo_cnt == TMO_LAST);

        case (state)
            S_IDLE: begin
                if (req_rise) begin
                    cc_d      = 1'b0;
                    bitcnt_d  = '0;
                    dly_cnt_d = '0;
                    waiting_d = 1'b0;
                    state_d   = S_C_DLY;
                end
            end
            S_C_DLY: begin
                if (waiting) begin
                    if (req_rise) begin
                        waiting_d = 1'b0;
                        dly_cnt_d = '0;
                    end
                end else if (req_fall) begin
                    // Host withdrew req before we acknowledged
                    fe_d    = 1'b1;
                    state_d = S_DONE;
                end else if (dly_cnt == DLY_LAST) begin
                    shift_d = {shift[15:0], data_s};
                    ack_d   = 1'b1;
                    state_d = S_C_ACK;
                end else begin
                    dly_cnt_d = dly_cnt + DW'(1);
                end
            end
            S_C_ACK: begin
                if (req_fall) begin
                    ack_d    = 1'b0;
                    bitcnt_d = bitcnt + 5'd1;
                    if (bitcnt == LAST_BIT) begin
                        cv_d    = 1'b1;
                        cw_d    = shift[16:1];
                        pe_d    = ~^shift;
                        state_d = (~^shift) ? S_DONE : S_EXEC;
                    end else begin
                        waiting_d = 1'b1;
                        state_d   = S_C_DLY;
                    end
                end
            end
            S_EXEC: begin
                if (req_rise) begin
                    fe_d    = 1'b1;
                    state_d = S_DONE;
                end else if (resp_valid) begin
                    if (resp_has_data) begin
                        tx_d     = {resp_word, odd_parity(resp_word)};
                        bitcnt_d = '0;
                        state_d  = S_R_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_R_WAIT: begin
                if (req_rise) begin
                    dly_cnt_d = '0;
                    state_d   = S_R_DLY;
                end
            end
            S_R_DLY: begin
                if (req_fall) begin
                    conf_d  = 1'b0;
                    fe_d    = 1'b1;
                    state_d = S_DONE;
                end else if (dly_cnt == DLY_FULL) begin
                    ack_d   = 1'b1;
                    state_d = S_R_ACK;
                end else begin
                    if (dly_cnt == DLY_LAST) begin
                        conf_d = tx[16];
                    end
                    dly_cnt_d = dly_cnt + DW'(1);
                end
            end
            S_R_ACK: begin
                if (req_fall) begin
                    ack_d    = 1'b0;
                    clr_d    = 1'b1;
                    tx_d     = {tx[15:0], 1'b0};
                    bitcnt_d = bitcnt + 5'd1;
                    state_d  = (bitcnt == LAST_BIT) ? S_DONE : S_R_WAIT;
                end
            end
            S_DONE: begin
                cc_d      = 1'b1;
                bitcnt_d  = '0;
                waiting_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_hit) begin
            ack_d     = 1'b0;
            conf_d    = 1'b0;
            fe_d      = 1'b1;
            waiting_d = 1'b0;
            state_d   = S_DONE;
        end
    end

    assign transfer_ack     = ack_q;
    assign confstat_data    = conf_q;
    assign command_complete = cc_q;
    assign cmd_valid        = cv_q;
    assign cmd_word         = cw_q;
    assign cmd_parity_err   = pe_q;
    assign frame_err        = fe_q;
    assign resp_ready       = (state == S_EXEC) && !req_rise;

endmodule

// File: tb/tb_esdi_drive_serial_responder.sv
// tb/tb_esdi_drive_serial_responder.sv - scoreboard bench for the ESDI drive serial responder
module tb_esdi_drive_serial_responder;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        transfer_req = 1'b0;
    logic        command_data = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_has_data = 1'b0;
    logic [15:0] resp_word = 16'h0;
    logic        transfer_ack, confstat_data, command_complete;
    logic        cmd_valid, cmd_parity_err, resp_ready, frame_err;
    logic [15:0] cmd_word;

    esdi_drive_serial_responder #(.SYNC_STAGES(2), .ACK_DELAY(4), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .transfer_req     (transfer_req),
        .command_data     (command_data),
        .transfer_ack     (transfer_ack),
        .confstat_data    (confstat_data),
        .command_complete (command_complete),
        .cmd_valid        (cmd_valid),
        .cmd_word         (cmd_word),
        .cmd_parity_err   (cmd_parity_err),
        .resp_valid       (resp_valid),
        .resp_has_data    (resp_has_data),
        .resp_word        (resp_word),
        .resp_ready       (resp_ready),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] exp_cmd[$];
    logic [16:0] exp_resp[$];
    bit          rd_phase = 1'b0;
    int          ack_rises = 0;
    logic        ack_prev = 1'b0;
    logic [16:0] rd_bits = '0;
    int          rd_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Monitor: decoded commands and host-read response words against the scoreboard
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (exp_cmd.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cmd_valid: got word %h perr %b expected none", cmd_word, cmd_parity_err);
            end else begin
                check("cmd_word_perr", {15'h0, cmd_word, cmd_parity_err}, {15'h0, exp_cmd.pop_front()});
            end
        end
        if (transfer_ack && !ack_prev) begin
            ack_rises++;
            if (rd_phase) begin
                rd_bits = {rd_bits[15:0], confstat_data};
                rd_n++;
                if (rd_n == 17) begin
                    rd_n = 0;
                    if (exp_resp.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: got %h expected none", rd_bits);
                    end else begin
                        check("resp_bits", {15'h0, rd_bits}, {15'h0, exp_resp.pop_front()});
                    end
                end
            end
        end
        ack_prev = transfer_ack;
    end

    task automatic wait_ack(input logic lvl, input string name);
        int n;
        n = 0;
        while (transfer_ack !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (transfer_ack !== lvl) flag(name);
    endtask

    task automatic send_bit(input logic b);
        command_data = b;
        @(negedge clk);
        transfer_req = 1'b1;
        wait_ack(1'b1, "cmd_ack_rise");
        transfer_req = 1'b0;
        wait_ack(1'b0, "cmd_ack_fall");
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic par);
        logic [16:0] f;
        int r0;
        f  = {w, par};
        r0 = ack_rises;
        for (int i = 16; i >= 0; i--) send_bit(f[i]);
        check("cmd_ack_count", ack_rises - r0, 17);
    endtask

    task automatic read_bit();
        transfer_req = 1'b1;
        wait_ack(1'b1, "resp_ack_rise");
        transfer_req = 1'b0;
        wait_ack(1'b0, "resp_ack_fall");
        @(negedge clk);
    endtask

    task automatic respond(input logic has, input logic [15:0] w);
        int n;
        n = 0;
        while (!resp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!resp_ready) flag("resp_ready_wait");
        resp_valid    = 1'b1;
        resp_has_data = has;
        resp_word     = w;
        @(negedge clk);
        resp_valid    = 1'b0;
    endtask

    task automatic wait_cc(input string name);
        int n;
        n = 0;
        while (!command_complete && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, command_complete, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", transfer_ack, 0);
        check("rst_confstat", confstat_data, 0);
        check("rst_cc", command_complete, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_resp_ready", resp_ready, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x1234 with parity 1: six ones in total -> parity error, no data phase
        exp_cmd.push_back({16'h1234, 1'b1});
        send_cmd(16'h1234, 1'b1);
        wait_cc("t1_cc");
        check("t1_resp_ready", resp_ready, 0);

        // 0x0000 with parity 1, answered with 0xA5C3 (parity 1)
        exp_cmd.push_back({16'h0000, 1'b0});
        send_cmd(16'h0000, 1'b1);
        exp_resp.push_back({16'hA5C3, 1'b1});
        respond(1'b1, 16'hA5C3);
        rd_phase = 1'b1;
        r0 = ack_rises;
        for (int i = 0; i < 17; i++) read_bit();
        rd_phase = 1'b0;
        check("t2_resp_ack_count", ack_rises - r0, 17);
        wait_cc("t2_cc");
        check("t2_confstat_idle", confstat_data, 0);

        // 0x0F00 with parity 1, no data phase: complete within 2 clks
        exp_cmd.push_back({16'h0F00, 1'b0});
        send_cmd(16'h0F00, 1'b1);
        respond(1'b0, 16'h0);
        n = 0;
        while (!command_complete && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("t3_cc_within_2", (n <= 2 && command_complete) ? 1 : 0, 1);

        // Host stalls after 9 bits: timeout frame error, no cmd_valid
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        n = 0;
        while (!frame_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_frame_err", frame_err, 1);
        check("t4_tmo_window", (n >= 95 && n <= 110) ? 1 : 0, 1);
        check("t4_ack_low", transfer_ack, 0);
        wait_cc("t4_cc");

        // Next full command after the timeout decodes correctly
        exp_cmd.push_back({16'h8001, 1'b0});
        send_cmd(16'h8001, 1'b1);
        respond(1'b0, 16'h0);
        wait_cc("t5_cc");

        // Reset asserted during response bit 5 while ack is high
        exp_cmd.push_back({16'h0000, 1'b0});
        send_cmd(16'h0000, 1'b1);
        respond(1'b1, 16'h5A5A);
        for (int i = 0; i < 5; i++) read_bit();
        transfer_req = 1'b1;
        wait_ack(1'b1, "t6_ack_rise");
        check("t6_ack_high", transfer_ack, 1);
        resetn = 1'b0;
        #1;
        check("t6_rst_ack", transfer_ack, 0);
        check("t6_rst_confstat", confstat_data, 0);
        check("t6_rst_cc", command_complete, 1);
        transfer_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        exp_cmd.push_back({16'h0F00, 1'b0});
        send_cmd(16'h0F00, 1'b1);
        respond(1'b0, 16'h0);
        wait_cc("t6_fresh_cc");

        // Host raises req while the responder waits in EXEC
        exp_cmd.push_back({16'h0F00, 1'b0});
        send_cmd(16'h0F00, 1'b1);
        check("t7_in_exec", resp_ready, 1);
        transfer_req = 1'b1;
        n = 0;
        while (!frame_err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_frame_err", frame_err, 1);
        check("t7_resp_ready", resp_ready, 0);
        wait_cc("t7_cc");
        check("t7_ack", transfer_ack, 0);
        transfer_req = 1'b0;
        repeat (4) @(negedge clk);

        check("sb_cmd_empty", exp_cmd.size(), 0);
        check("sb_resp_empty", exp_resp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
